// File: rtl/avalon_sink.sv
// rtl/avalon_sink.sv - Avalon-ST ready-latency-1 sink with FIFO, beat counter and violation flag
module avalon_sink #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sink_en,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  beat_count,
  output logic              protocol_error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(DEPTH);

  logic              ready_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  count;
  logic [OCC_W-1:0]  count_next;
  logic              accept;
  logic              violation;
  logic              push;
  logic              pop;
  logic              ready_next;

  // Accept/violate decisions use last cycle's ready; occupancy look-ahead drives next ready.
  always_comb begin
    accept     = valid && ready_q;
    violation  = valid && !ready_q;
    push       = accept;
    pop        = out_valid && out_ready;
    count_next = count + OCC_W'(push) - OCC_W'(pop);
    // Reserve a slot for a beat that may still arrive because ready is high now.
    ready_next = sink_en && (({1'b0, count_next} + (OCC_W + 1)'(ready)) < DEPTH_L);
  end

  // Head of FIFO is presented directly from registers; zeroed when empty.
  always_comb begin
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

  // Ready handshake registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready   <= ready_next;
      ready_q <= ready;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // FIFO storage; contents are don't-care until count marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // Saturating accepted-beat counter and sticky violation flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_count     <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (accept && (beat_count != {CNT_W{1'b1}})) beat_count <= beat_count + CNT_W'(1);
      if (violation) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_sink.sv
// tb/tb_avalon_sink.sv - randomized self-checking bench for avalon_sink against a queue model
module tb_avalon_sink;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              sink_en;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  beat_count;
  logic              protocol_error;

  avalon_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .sink_en        (sink_en),
    .valid          (valid),
    .data           (data),
    .ready          (ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .beat_count     (beat_count),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int mq[$];
  bit m_ready   = 0;
  bit m_ready_q = 0;
  int m_cnt     = 0;
  bit m_err     = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model across one clock edge.
  task automatic step();
    bit acc;
    bit viol;
    bit nr;
    check("ready", int'(ready), int'(m_ready));
    check("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
    check("out_data", int'(out_data), (mq.size() != 0) ? mq[0] : 0);
    check("beat_count", int'(beat_count), m_cnt);
    check("protocol_error", int'(protocol_error), int'(m_err));
    if (!resetn) begin
      mq.delete();
      m_ready = 0; m_ready_q = 0; m_cnt = 0; m_err = 0;
    end else begin
      acc  = valid && m_ready_q;
      viol = valid && !m_ready_q;
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (acc) mq.push_back(int'(data));
      nr = sink_en && ((mq.size() + int'(m_ready)) < DEPTH);
      m_ready_q = m_ready;
      m_ready   = nr;
      if (acc && m_cnt < CNT_MAX) m_cnt++;
      if (viol) m_err = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int v;
    int n;
    resetn = 0; sink_en = 1; valid = 1; data = 8'h0; out_ready = 1;
    @(posedge clk);
    @(negedge clk);

    // Reset and idle
    repeat (3) step();
    resetn = 1; valid = 0;
    step();
    check("ready_after_release", int'(ready), 1);
    check("err_after_release", int'(protocol_error), 0);

    // Source 4,5,6 with consumer always ready
    v = 4; n = 0;
    while (v <= 6 && n < 20) begin
      valid = m_ready_q; data = DATA_W'(v);
      step();
      if (valid) v++;
      n++;
    end
    valid = 0;
    repeat (3) step();
    check("beats_456", int'(beat_count), 3);

    // Fill with consumer stalled, then drain
    out_ready = 0; v = 1;
    repeat (12) begin
      valid = m_ready_q && (v <= 8); data = DATA_W'(v);
      step();
      if (valid) v++;
    end
    check("fill_stored", v - 1, 4);
    check("fill_ready_low", int'(ready), 0);
    check("fill_head", int'(out_data), 1);
    out_ready = 1; n = 0;
    while (n < 20) begin
      valid = m_ready_q && (v <= 8); data = DATA_W'(v);
      step();
      if (valid) v++;
      n++;
    end
    valid = 0;
    repeat (2) step();
    check("fill_beats", int'(beat_count), 11);

    // Ready-fall grace beat
    sink_en = 1;
    repeat (3) begin
      valid = m_ready_q; data = DATA_W'($urandom);
      step();
    end
    sink_en = 0;
    repeat (3) begin
      valid = 1; data = DATA_W'($urandom);
      step();
    end
    valid = 0;
    step();
    check("grace_err", int'(protocol_error), 1);

    // Counter saturation after a fresh reset
    resetn = 0; sink_en = 1;
    step();
    resetn = 1;
    v = 0; n = 0;
    while (v < 20 && n < 60) begin
      valid = m_ready_q; data = DATA_W'($urandom);
      step();
      if (valid) v++;
      n++;
    end
    valid = 0;
    repeat (3) step();
    check("sat_count", int'(beat_count), CNT_MAX);
    check("sat_err", int'(protocol_error), 0);

    // Randomized traffic with occasional resets and rare violations
    repeat (2000) begin
      resetn    = ($urandom % 50) != 0;
      sink_en   = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      valid     = m_ready_q ? (($urandom % 4) != 0) : (($urandom % 64) == 0);
      data      = DATA_W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_sink.md
# avalon_sink

Avalon-ST sink with ready latency 1: the receiving end of the team's 8-bit streaming sources. It drives `ready`, captures every beat the source presents, and buffers beats in a small FIFO. It re-issues the beats on a zero-latency valid/ready port toward the local consumer. It also counts accepted beats and flags source protocol violations.

## Interface
- `DATA_W`, default 8: stream data width.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, default 16: width of `beat_count`.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `resetn`  in  1  synchronous, active-low reset.
- `sink_en`  in  1  consumer permission to accept stream data; gates `ready`.
- `valid`  in  1  source data valid.
- `data`  in  DATA_W  source data.
- `ready`  out  1  sink ready; ready latency 1.
- `out_valid`  out  1  FIFO head available.
- `out_ready`  in  1  consumer pops head when high with `out_valid`.
- `out_data`  out  DATA_W  FIFO head; 0 when `out_valid`=0.
- `beat_count`  out  CNT_W  accepted beats; saturates at all-ones.
- `protocol_error`  out  1  sticky violation flag.

## Operation
- `ready_q` is a register holding `ready` from the previous cycle.
- Accept condition: `accept = valid && ready_q`. This is the ready-latency-1 rule: a beat is legal in the cycle after `ready` was high, including the cycle after `ready` falls.
- Violation condition: `valid && !ready_q`. On a violation:
  - the beat is dropped, not written;
  - `protocol_error` sets and holds until reset.
- `ready` is registered. Its next value is `sink_en && (count_next + ready_next_inflight) < DEPTH`, where:
  - `count_next` is the occupancy after this cycle's push/pop;
  - `ready_next_inflight` is the current `ready`, i.e. a possible beat next cycle.
  - The FIFO therefore never overflows, whatever the source does with legal timing.
- FIFO behaviour:
  - circular buffer with `rd_ptr`, `wr_ptr` of log2(DEPTH) bits, wrapping modulo DEPTH, plus `count` of 0..DEPTH;
  - push on `accept`, pop on `out_valid && out_ready`;
  - simultaneous push and pop: count unchanged, both pointers advance;
  - pop when empty is impossible, because `out_valid`=0;
  - push when full cannot occur under legal source timing, because `ready` guarantees space.
- `out_valid = (count != 0)`, and `out_data = mem[rd_ptr]` when valid, else 0. Both are combinational from registers.
- `beat_count` increments by 1 on each `accept` and saturates at 2^CNT_W-1. Violating beats are not counted.
- Dropping `sink_en` stops new `ready`. A beat already in flight (`ready_q`=1) is still accepted, and the FIFO keeps draining.

## Timing
- Reset values, while `resetn`=0 at a clock edge:
  - `ready`=0, `ready_q`=0;
  - `count`=0, pointers=0, so `out_valid`=0 and `out_data`=0;
  - `beat_count`=0, `protocol_error`=0.
- Reset mid-transfer discards FIFO contents.
- `ready` first rises the cycle after `resetn` deasserts, if `sink_en`=1.
- Latency from input to output: a beat accepted at edge N appears on `out_valid`/`out_data` after edge N, i.e. 1 cycle. This holds even when popped the same cycle as other traffic.
- Throughput: 1 beat/cycle sustained when the consumer holds `out_ready`=1.
- Backpressure:
  - with `out_ready`=0, `ready` falls in the cycle after the edge where `count + ready` reaches DEPTH;
  - the one in-flight beat is still absorbed;
  - `ready` re-rises the cycle after a pop frees space.
- `protocol_error` rises on the edge following the offending cycle.

## Test plan
- Reset and idle:
  - stimulus: hold `resetn`=0 for 3 cycles with `valid`=1; then release with `sink_en`=1 and `valid`=0;
  - required response: all outputs at their reset values during reset; `ready`=1 one cycle after release; `protocol_error`=0.
- Source 4,5,6 with `out_ready`=1:
  - stimulus: the source waits for `ready`, then presents 4,5,6 on consecutive cycles;
  - required response: `out_data` shows 4,5,6 each one cycle later; `beat_count`=3; `protocol_error`=0.
- Fill, DEPTH=4:
  - stimulus: `out_ready`=0 with a continuous source sending 1..8;
  - required response: exactly 4 beats (1..4) stored; `ready` low thereafter; no overwrite.
  - Then `out_ready`=1: `out_data` shows 1,2,3,4, followed by 5.. in order; pointers wrap cleanly.
- Ready-fall grace beat:
  - stimulus: drop `sink_en` in cycle T while the source holds `valid` through T+1;
  - required response: the beat at T+1 is accepted and counted; `valid` at T+2 sets `protocol_error`, and that beat is dropped.
- Simultaneous push/pop at count=2:
  - stimulus: `accept` and pop in the same cycle;
  - required response: count stays 2; order preserved.
- Counter saturation, CNT_W=4:
  - stimulus: 20 beats;
  - required response: `beat_count`=15 held; data path unaffected.
